// File: rtl/mux_nx1_pipe.sv
// N-input, WIDTH-bit select mux with a registered output, valid/stall/flush control and
// out-of-range select detection. Define MUX_ERR_CNT_EN to build the saturating error counter.
module mux_nx1_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_IN      = 3,
  parameter int unsigned DEFAULT_IDX = 0,
  parameter int unsigned CNT_W       = 8,
  localparam int unsigned SEL_W      = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        err_count
);

  logic             illegal;
  logic [WIDTH-1:0] sel_data;
  logic             load;

  // With a power-of-two fan-in every select value names a real input.
  if ((1 << SEL_W) == NUM_IN) begin : g_pow2
    assign illegal = 1'b0;
  end else begin : g_npow2
    assign illegal = (sel >= SEL_W'(NUM_IN));
  end

  always_comb begin
    sel_data = in_bus[DEFAULT_IDX*WIDTH +: WIDTH];
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  assign load = !flush && !stall;

  // Flush clears the qualifiers but leaves out_data as it was.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else if (!stall) begin
      out_data  <= sel_data;
      out_valid <= in_valid;
      sel_err   <= illegal & in_valid;
    end
  end

`ifdef MUX_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (err_clr) begin
      err_cnt_q <= '0;
    end else if (load && in_valid && illegal && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr ^ load;
  assign err_count      = '0;
`endif

endmodule
